ifu_fetch: RTL and testbench

Instruction fetch unit. It is the producer side of the decode-stage instruction interface: it drives inst/pc into the decode stage and obeys the decode stage's pipe_stop hold semantics. It fetches from instruction memory over a valid/ready request channel and a fixed-order response channel, with one outstanding request. It holds one fetched instruction in a single-entry buffer and redirects on branch, jump, ecall or mret targets supplied by the execute/CSR logic.

---
 rtl/ifu_fetch.sv | 171 +++++++++++++++++
 tb/tb_ifu_fetch.sv | 402 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : ifu_fetch
// Purpose  : Instruction fetch unit. Issues one word-aligned fetch at a time
//            to instruction memory, holds the returned word in a single-entry
//            buffer presented to decode, and redirects on branch/jump/trap
//            targets from execute/CSR logic.
// Ports    :
//   clk             - clock, all state updates on rising edge
//   rst_n           - asynchronous active-low reset
//   pipe_stop       - decode holding; presented inst/pc are not consumed
//   redirect_valid  - one-cycle flush request, refetch from redirect_pc
//   redirect_pc     - new fetch target (low two bits ignored)
//   imem_req_valid  - fetch request valid (held stable until accepted)
//   imem_req_addr   - fetch address, word aligned
//   imem_req_ready  - memory accepts the request this cycle
//   imem_resp_valid - response data valid (no backpressure)
//   imem_resp_data  - fetched instruction word
//   inst            - instruction to decode, 32'h0 when no instruction valid
//   pc              - pc of inst
//   fetch_busy      - a fetch is being requested or awaited
// Revision : 1.0 - initial release
// ============================================================================
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pipe_stop,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        fetch_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_fetch_pc;
  logic [31:0] r_req_addr;
  logic        r_drop;
  logic        r_buf_valid;
  logic [31:0] r_buf_inst;
  logic [31:0] r_buf_pc;

  logic [31:0] w_redirect_aligned;
  logic        w_consume;
  logic        w_resp;

  assign w_redirect_aligned = {redirect_pc[31:2], 2'b00};
  // A redirect wins over consumption: the presented word is being flushed.
  assign w_consume          = r_buf_valid && !pipe_stop && !redirect_valid;
  // Responses outside WAIT (e.g. a late one after reset) are ignored.
  assign w_resp             = (r_state == WAIT) && imem_resp_valid;

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: w_state_next = REQ;
      // The request is never withdrawn, even on redirect; the stale
      // response is dropped instead.
      REQ:  if (imem_req_ready) w_state_next = WAIT;
      WAIT: begin
        if (imem_resp_valid) begin
          if (redirect_valid || r_drop) w_state_next = REQ;
          else                          w_state_next = HOLD;
        end
      end
      // Leave HOLD once the buffer has actually drained (or is flushed), so
      // the next request always targets the updated fetch_pc.
      HOLD: if (redirect_valid || !r_buf_valid) w_state_next = REQ;
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Fetch address, drop flag and instruction buffer
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_pc  <= RESET_PC;
      r_req_addr  <= RESET_PC;
      r_drop      <= 1'b0;
      r_buf_valid <= 1'b0;
      r_buf_inst  <= 32'h0;
      r_buf_pc    <= 32'h0;
    end else begin
      if (w_consume) begin
        r_buf_valid <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          r_req_addr <= redirect_valid ? w_redirect_aligned : r_fetch_pc;
        end
        REQ: begin
          if (redirect_valid) r_drop <= 1'b1;
        end
        WAIT: begin
          if (w_resp) begin
            if (redirect_valid) begin
              // Same-cycle redirect: the response is discarded here, so no
              // drop is left pending for the refetch.
              r_drop     <= 1'b0;
              r_req_addr <= w_redirect_aligned;
            end else if (r_drop) begin
              r_drop     <= 1'b0;
              r_req_addr <= r_fetch_pc;
            end else begin
              r_buf_valid <= 1'b1;
              r_buf_inst  <= imem_resp_data;
              r_buf_pc    <= r_req_addr;
              r_fetch_pc  <= r_req_addr + 32'd4;
            end
          end else if (redirect_valid) begin
            r_drop <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect_valid)    r_req_addr <= w_redirect_aligned;
          else if (!r_buf_valid) r_req_addr <= r_fetch_pc;
        end
        default: ;
      endcase

      // Redirect overrides any fetch_pc increment and buffer update above.
      if (redirect_valid) begin
        r_fetch_pc  <= w_redirect_aligned;
        r_buf_valid <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_req_addr;
  assign inst           = (r_buf_valid && !redirect_valid) ? r_buf_inst : 32'h0;
  assign pc             = r_buf_pc;
  assign fetch_busy     = (r_state == REQ) || (r_state == WAIT);

endmodule
`default_nettype wire

// File: tb/tb_ifu_fetch.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ifu_fetch
// Purpose  : Self-checking bench for ifu_fetch. A behavioural instruction
//            memory answers accepted requests after a programmable latency;
//            expected {pc, inst} pairs are queued when a request for the
//            expected fetch address is accepted and popped when decode
//            consumes an instruction.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ifu_fetch;

  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_stop;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        fetch_busy;

  always #5 clk = ~clk;

  ifu_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .pipe_stop       (pipe_stop),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .inst            (inst),
    .pc              (pc),
    .fetch_busy      (fetch_busy)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_fetch = RESET_PC;
  logic [31:0] pend_addr = 32'h0;
  int          pend_cnt  = -1;
  int          lat       = 1;
  logic        auto_ready = 1'b1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8000_0000) return 32'h0000_0413;
    return a ^ 32'h1234_5673;  // never zero for aligned addresses
  endfunction

  // Drive this cycle's memory-side inputs; called once per cycle after the
  // test has set pipe_stop/redirect.
  task automatic drive();
    exp_t e;
    if (redirect_valid) begin
      sb.delete();
      exp_fetch = {redirect_pc[31:2], 2'b00};
    end
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    if (pend_cnt == 0) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr);
      pend_cnt        = -1;
    end else if (pend_cnt > 0) begin
      pend_cnt = pend_cnt - 1;
    end
    imem_req_ready = auto_ready;
    if (imem_req_valid && imem_req_ready) begin
      pend_addr = imem_req_addr;
      pend_cnt  = lat - 1;
      if (!redirect_valid && imem_req_addr == exp_fetch) begin
        e.pc   = imem_req_addr;
        e.inst = mem_word(imem_req_addr);
        sb.push_back(e);
        exp_fetch = exp_fetch + 32'd4;
      end
    end
    #1;
  endtask

  // Score a consumed instruction, then advance one clock.
  task automatic adv();
    exp_t e;
    if (inst !== 32'h0 && !pipe_stop && !redirect_valid) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected inst=%h pc=%h required no instruction", inst, pc);
      end else begin
        e = sb.pop_front();
        if (inst !== e.inst || pc !== e.pc) begin
          errors++;
          $display("FAIL sb_consume inst=%h pc=%h required inst=%h pc=%h", inst, pc, e.inst, e.pc);
        end
      end
    end
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
  endtask

  task automatic cyc();
    drive();
    adv();
  endtask

  task automatic wait_req();
    int n = 0;
    while (!imem_req_valid && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic wait_inst();
    int n = 0;
    while (inst === 32'h0 && n < 20) begin
      cyc();
      n++;
    end
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 40) begin
      cyc();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; pipe_stop = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (imem_req_valid !== 1'b0 || fetch_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl req_valid=%b busy=%b required 0 0", imem_req_valid, fetch_busy);
    end
    checks++;
    if (inst !== 32'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL reset_data inst=%h pc=%h required 0 0", inst, pc);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_release req_valid=%b required 0", imem_req_valid);
    end
    cyc();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC || fetch_busy !== 1'b1) begin
      errors++;
      $display("FAIL first_req valid=%b addr=%h busy=%b required 1 %h 1",
               imem_req_valid, imem_req_addr, fetch_busy, RESET_PC);
    end
  endtask

  task automatic test_basic();
    cyc();
    drive();
    checks++;
    if (fetch_busy !== 1'b1 || inst !== 32'h0) begin
      errors++;
      $display("FAIL basic_wait busy=%b inst=%h required 1 0", fetch_busy, inst);
    end
    adv();
    drive();
    checks++;
    if (inst !== 32'h0000_0413 || pc !== 32'h8000_0000) begin
      errors++;
      $display("FAIL basic_inst inst=%h pc=%h required 00000413 80000000", inst, pc);
    end
    adv();
    wait_req();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0004) begin
      errors++;
      $display("FAIL basic_next valid=%b addr=%h required 1 80000004", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_pipe_stop();
    pipe_stop = 1'b1;
    wait_inst();
    for (int i = 0; i < 5; i++) begin
      drive();
      checks++;
      if (inst !== mem_word(32'h8000_0004) || pc !== 32'h8000_0004 || imem_req_valid !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold[%0d] inst=%h pc=%h req_valid=%b required %h 80000004 0",
                 i, inst, pc, imem_req_valid, mem_word(32'h8000_0004));
      end
      adv();
    end
    pipe_stop = 1'b0;
    cyc();
    wait_req();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008 || sb.size() != 0) begin
      errors++;
      $display("FAIL stall_release valid=%b addr=%h pending=%0d required 1 80000008 0",
               imem_req_valid, imem_req_addr, sb.size());
    end
  endtask

  task automatic test_redirect_req();
    int n = 0;
    auto_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h8000_0103;
      end
      if (i == 3) auto_ready = 1'b1;
      drive();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0008 || inst !== 32'h0) begin
        errors++;
        $display("FAIL req_stable[%0d] valid=%b addr=%h inst=%h required 1 80000008 0",
                 i, imem_req_valid, imem_req_addr, inst);
      end
      adv();
    end
    while (!imem_req_valid && n < 20) begin
      drive();
      checks++;
      if (inst !== 32'h0) begin
        errors++;
        $display("FAIL req_dropped inst=%h required 0", inst);
      end
      adv();
      n++;
    end
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0100) begin
      errors++;
      $display("FAIL req_redirect_target valid=%b addr=%h required 1 80000100", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_wait();
    lat = 1;
    cyc();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    drive();
    checks++;
    if (inst !== 32'h0 || fetch_busy !== 1'b1 || imem_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL wait_redirect inst=%h busy=%b required 0 1", inst, fetch_busy);
    end
    adv();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0200) begin
      errors++;
      $display("FAIL wait_redirect_req valid=%b addr=%h required 1 80000200", imem_req_valid, imem_req_addr);
    end
    cyc();
    cyc();
    drive();
    checks++;
    if (inst !== mem_word(32'h8000_0200) || pc !== 32'h8000_0200) begin
      errors++;
      $display("FAIL wait_no_drop inst=%h pc=%h required %h 80000200", inst, pc, mem_word(32'h8000_0200));
    end
    adv();
    wait_req();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0204) begin
      errors++;
      $display("FAIL wait_next valid=%b addr=%h required 1 80000204", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_redirect_hold();
    pipe_stop = 1'b1;
    wait_inst();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0300;
    drive();
    checks++;
    if (inst !== 32'h0) begin
      errors++;
      $display("FAIL hold_redirect_pulse inst=%h required 0", inst);
    end
    adv();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h8000_0300 || inst !== 32'h0) begin
      errors++;
      $display("FAIL hold_redirect_req valid=%b addr=%h inst=%h required 1 80000300 0",
               imem_req_valid, imem_req_addr, inst);
    end
    pipe_stop = 1'b0;
    cyc();
    drain();
    wait_req();
    checks++;
    if (sb.size() != 0 || imem_req_addr !== 32'h8000_0304) begin
      errors++;
      $display("FAIL hold_after pending=%0d addr=%h required 0 80000304", sb.size(), imem_req_addr);
    end
  endtask

  task automatic test_wrap();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    cyc();
    wait_req();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'hFFFF_FFFC) begin
      errors++;
      $display("FAIL wrap_target valid=%b addr=%h required 1 fffffffc", imem_req_valid, imem_req_addr);
    end
    cyc();
    drain();
    wait_req();
    checks++;
    if (sb.size() != 0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0000_0000) begin
      errors++;
      $display("FAIL wrap_next pending=%0d valid=%b addr=%h required 0 1 00000000",
               sb.size(), imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_reset_wait();
    lat = 3;
    cyc();
    checks++;
    if (fetch_busy !== 1'b1 || imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstw_in_wait busy=%b req_valid=%b required 1 0", fetch_busy, imem_req_valid);
    end
    rst_n = 1'b0;
    #1;
    sb.delete();
    exp_fetch = RESET_PC;
    checks++;
    if (imem_req_valid !== 1'b0 || fetch_busy !== 1'b0 || inst !== 32'h0 || pc !== 32'h0) begin
      errors++;
      $display("FAIL rstw_async valid=%b busy=%b inst=%h pc=%h required 0 0 0 0",
               imem_req_valid, fetch_busy, inst, pc);
    end
    cyc();
    rst_n = 1'b1;
    cyc();
    checks++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== RESET_PC) begin
      errors++;
      $display("FAIL rstw_first_req valid=%b addr=%h required 1 %h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    cyc();
    drain();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rstw_deliver pending=%0d required 0", sb.size());
    end
    lat = 1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pipe_stop();
    test_redirect_req();
    test_redirect_wait();
    test_redirect_hold();
    test_wrap();
    test_reset_wait();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
